// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline-front control logic.
//   state_e     : fetch controller states (INIT, RUN, FLUSH, HALT)
//   HALT_OPCODE : encoding of the HALT instruction seen in IF/ID
//   REG_ZERO    : architectural zero register, never a real hazard source
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_e;

    localparam logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF;
    localparam int unsigned REG_ZERO    = 0;

endpackage

// File: rtl/fetch_ctrl_hazard_detect.sv
// Combinational load-use comparator.
//   ex_mem_read_i : instruction in ID/EX is a load
//   ex_rt_i       : destination register of that load
//   id_rs_i       : source register 1 of the instruction in IF/ID
//   id_rt_i       : source register 2 of the instruction in IF/ID
//   hazard_o      : the IF/ID instruction needs the load result next cycle
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    output logic             hazard_o
);

    // A load into the zero register produces nothing to wait for.
    assign hazard_o = ex_mem_read_i
                   && (ex_rt_i != REG_W'(REG_ZERO))
                   && ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: drives PC load/select, IF/ID load/clear and the
// ID/EX bubble, arbitrating branch redirect, halt, load-use stall and
// debug single-step gating. Keeps saturating stall/flush counters.
//   clock, reset_n      : rising-edge clock, async active-low reset
//   branch_taken        : branch resolved taken this cycle
//   id_rs, id_rt        : sources of the IF/ID instruction
//   id_halt             : IF/ID instruction is HALT
//   ex_mem_read, ex_rt  : ID/EX load flag and destination
//   step_mode, step_req : debug single-step enable and advance pulse
//   resume              : leave HALT
//   pc_write, pc_src    : PC load enable and mux select (1 = branch target)
//   ifid_write/flush    : IF/ID load enable and clear-to-NOP
//   idex_bubble         : force NOP into ID/EX
//   pipe_en             : advance enable for ID/EX and later
//   halted              : registered HALT indicator
//   stall_cnt/flush_cnt : saturating debug counters
module fetch_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_DEPTH = 2,
    parameter int REG_W       = 5,
    parameter int CNT_W       = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             branch_taken,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_halt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             step_mode,
    input  logic             step_req,
    input  logic             resume,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Flush cycles still owed after the branch cycle itself.
    localparam logic [2:0] REMAIN_RELOAD = 3'(FLUSH_DEPTH - 1);
    localparam bit         MULTI_FLUSH   = (FLUSH_DEPTH > 1);

    state_e           state_q, state_d;
    logic [2:0]       remain_q, remain_d;
    logic             resumeFlush_q, resumeFlush_d;
    logic             halted_q;
    logic [CNT_W-1:0] stallCnt_q, flushCnt_q;
    logic             stallInc, flushInc, doBranch, hazard;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .ex_mem_read_i (ex_mem_read),
        .ex_rt_i       (ex_rt),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .hazard_o      (hazard)
    );

    // Next state and Mealy strobes. A taken branch is resolved after the
    // per-state case so that it overrides every other request in RUN, FLUSH
    // and HALT. resumeFlush_q marks the first RUN cycle after HALT: the held
    // HALT instruction is cleared out of IF/ID instead of being decoded again.
    always_comb begin
        state_d       = state_q;
        remain_d      = remain_q;
        resumeFlush_d = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        ifid_write    = 1'b0;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        pipe_en       = 1'b0;
        stallInc      = 1'b0;
        flushInc      = 1'b0;
        doBranch      = 1'b0;

        case (state_q)
            INIT: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                pipe_en     = 1'b1;
                state_d     = RUN;
            end
            RUN: begin
                if (branch_taken) begin
                    doBranch = 1'b1;
                end else if (resumeFlush_q) begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    ifid_flush = 1'b1;
                    pipe_en    = 1'b1;
                end else if (id_halt) begin
                    idex_bubble = 1'b1;
                    pipe_en     = 1'b1;
                    state_d     = HALT;
                end else if (hazard) begin
                    idex_bubble = 1'b1;
                    pipe_en     = 1'b1;
                    stallInc    = 1'b1;
                end else if (step_mode && !step_req) begin
                    pipe_en = 1'b0;
                end else begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    pipe_en    = 1'b1;
                end
            end
            FLUSH: begin
                if (branch_taken) begin
                    doBranch = 1'b1;
                end else begin
                    pc_write    = 1'b1;
                    ifid_write  = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    pipe_en     = 1'b1;
                    flushInc    = 1'b1;
                    remain_d    = remain_q - 3'd1;
                    if (remain_q == 3'd1) begin
                        state_d = RUN;
                    end
                end
            end
            HALT: begin
                if (branch_taken) begin
                    doBranch = 1'b1;
                end else begin
                    idex_bubble = 1'b1;
                    pipe_en     = 1'b1;
                    if (resume) begin
                        state_d       = RUN;
                        resumeFlush_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase

        if (doBranch) begin
            pc_write    = 1'b1;
            pc_src      = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            pipe_en     = 1'b1;
            flushInc    = 1'b1;
            if (MULTI_FLUSH) begin
                state_d  = FLUSH;
                remain_d = REMAIN_RELOAD;
            end else begin
                state_d = RUN;
            end
        end
    end

    // State, halt flag and saturating counters. halted mirrors the state
    // being entered so it rises on the same edge that enters HALT.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= INIT;
            remain_q      <= '0;
            resumeFlush_q <= 1'b0;
            halted_q      <= 1'b0;
            stallCnt_q    <= '0;
            flushCnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            remain_q      <= remain_d;
            resumeFlush_q <= resumeFlush_d;
            halted_q      <= (state_d == HALT);
            if (stallInc && (stallCnt_q != '1)) begin
                stallCnt_q <= stallCnt_q + CNT_W'(1);
            end
            if (flushInc && (flushCnt_q != '1)) begin
                flushCnt_q <= flushCnt_q + CNT_W'(1);
            end
        end
    end

    assign halted    = halted_q;
    assign stall_cnt = stallCnt_q;
    assign flush_cnt = flushCnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: each stimulus cycle pushes its
// hand-computed expected outputs, and a monitor pops and compares them at
// the falling edge of the same cycle.
module tb_fetch_ctrl;

    // Strobe order: {pc_write, pc_src, ifid_write, ifid_flush, idex_bubble, pipe_en}
    localparam logic [5:0] ADV    = 6'b101001;
    localparam logic [5:0] INITP  = 6'b000111;
    localparam logic [5:0] STALL  = 6'b000011;
    localparam logic [5:0] BRANCH = 6'b111111;
    localparam logic [5:0] FLUSHP = 6'b101111;
    localparam logic [5:0] FROZEN = 6'b000000;
    localparam logic [5:0] RESFL  = 6'b101101;

    typedef struct packed {
        logic [5:0] strobe;
        logic       halted;
        logic [7:0] stall;
        logic [7:0] flush;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       branch_taken, id_halt, ex_mem_read, step_mode, step_req, resume;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       pc_write, pc_src, ifid_write, ifid_flush, idex_bubble, pipe_en, halted;
    logic [7:0] stall_cnt, flush_cnt;

    exp_t  expQ[$];
    string tagQ[$];
    int    vecCount  = 0;
    int    missCount = 0;

    fetch_ctrl #(.FLUSH_DEPTH(2), .REG_W(5), .CNT_W(8)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .branch_taken (branch_taken),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_halt      (id_halt),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .step_mode    (step_mode),
        .step_req     (step_req),
        .resume       (resume),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .pipe_en      (pipe_en),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clock = ~clock;

    // Drive one cycle of inputs just after the rising edge and queue the
    // outputs expected during that cycle.
    task automatic applyStimulus(input logic rstN, input logic br, input logic hlt,
                                 input logic mr, input logic [4:0] exRt,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic sm, input logic sr, input logic res,
                                 input logic [5:0] expStrobe, input logic expHalted,
                                 input int expStall, input int expFlush,
                                 input string tag);
        exp_t e;
        @(posedge clock);
        #1;
        reset_n      = rstN;
        branch_taken = br;
        id_halt      = hlt;
        ex_mem_read  = mr;
        ex_rt        = exRt;
        id_rs        = rs;
        id_rt        = rt;
        step_mode    = sm;
        step_req     = sr;
        resume       = res;
        e.strobe = expStrobe;
        e.halted = expHalted;
        e.stall  = 8'(expStall);
        e.flush  = 8'(expFlush);
        expQ.push_back(e);
        tagQ.push_back(tag);
    endtask

    task automatic applyIdle(input logic [5:0] expStrobe, input logic expHalted,
                             input int expStall, input int expFlush, input string tag);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0,
                      expStrobe, expHalted, expStall, expFlush, tag);
    endtask

    // Monitor: compare whatever the DUT presents against the oldest entry.
    task automatic checkOutput(input exp_t e, input string tag);
        logic [5:0] got;
        got = {pc_write, pc_src, ifid_write, ifid_flush, idex_bubble, pipe_en};
        vecCount++;
        if (got !== e.strobe || halted !== e.halted ||
            stall_cnt !== e.stall || flush_cnt !== e.flush) begin
            missCount++;
            $display("[TB] FAIL %s: got strobes=%b halted=%b stall=%0d flush=%0d, want strobes=%b halted=%b stall=%0d flush=%0d",
                     tag, got, halted, stall_cnt, flush_cnt,
                     e.strobe, e.halted, e.stall, e.flush);
        end
    endtask

    initial begin
        exp_t  e;
        string t;
        forever begin
            @(negedge clock);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                t = tagQ.pop_front();
                checkOutput(e, t);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0; branch_taken = 1'b0; id_halt = 1'b0; ex_mem_read = 1'b0;
        step_mode = 1'b0; step_req = 1'b0; resume = 1'b0;
        id_rs = '0; id_rt = '0; ex_rt = '0;

        // Reset and INIT
        applyStimulus(0,0,0,0,0,0,0,0,0,0, INITP,0,0,0, "inReset0");
        applyStimulus(0,0,0,0,0,0,0,0,0,0, INITP,0,0,0, "inReset1");
        applyIdle(INITP,0,0,0, "initState");
        applyIdle(ADV,0,0,0, "firstRun");

        // Load-use detection
        applyStimulus(1,0,0,1,5,5,0,0,0,0, STALL,0,0,0, "loadUseRs");
        applyIdle(ADV,0,1,0, "afterStall");
        applyStimulus(1,0,0,1,0,0,0,0,0,0, ADV,0,1,0, "loadRtZero");
        applyStimulus(1,0,0,1,7,1,7,0,0,0, STALL,0,1,0, "loadUseRt");
        applyStimulus(1,0,0,0,7,7,7,0,0,0, ADV,0,2,0, "noLoad");

        // Branch flush sequence, branch over hazard, branch reload in FLUSH
        applyStimulus(1,1,0,0,0,0,0,0,0,0, BRANCH,0,2,0, "branch0");
        applyIdle(FLUSHP,0,2,1, "branch1");
        applyIdle(ADV,0,2,2, "branch2");
        applyStimulus(1,1,0,1,5,5,0,0,0,0, BRANCH,0,2,2, "brOverHazard");
        applyStimulus(1,0,0,0,0,0,0,1,0,0, FLUSHP,0,2,3, "flushIgnoresStep");
        applyIdle(ADV,0,2,4, "brHazardDone");
        applyStimulus(1,1,0,0,0,0,0,0,0,0, BRANCH,0,2,4, "branchA");
        applyStimulus(1,1,0,0,0,0,0,0,0,0, BRANCH,0,2,5, "branchInFlush");
        applyIdle(FLUSHP,0,2,6, "reloadFlush");
        applyIdle(ADV,0,2,7, "reloadDone");

        // Halt, hold, resume
        applyStimulus(1,0,1,0,0,0,0,0,0,0, STALL,0,2,7, "haltReq");
        for (int i = 0; i < 10; i++)
            applyStimulus(1,0,1,0,0,0,0,0,0,0, STALL,1,2,7, "haltHold");
        applyStimulus(1,0,1,0,0,0,0,0,0,1, STALL,1,2,7, "resumePulse");
        applyStimulus(1,0,1,0,0,0,0,0,0,0, RESFL,0,2,7, "resumeFlush");
        applyIdle(ADV,0,2,7, "afterResume");

        // Branch honoured in HALT
        applyStimulus(1,0,1,0,0,0,0,0,0,0, STALL,0,2,7, "halt2");
        applyStimulus(1,1,1,0,0,0,0,0,0,0, BRANCH,1,2,7, "branchInHalt");
        applyIdle(FLUSHP,0,2,8, "haltBrFlush");
        applyIdle(ADV,0,2,9, "haltBrDone");

        // Single step: advance only on the step_req cycles
        for (int i = 0; i < 10; i++) begin
            logic sr;
            sr = (i == 3) || (i == 7);
            applyStimulus(1,0,0,0,0,0,0,1,sr,0, sr ? ADV : FROZEN,0,2,9, "singleStep");
        end

        // Stall counter saturation
        for (int i = 0; i < 300; i++)
            applyStimulus(1,0,0,1,5,5,5,0,0,0, STALL,0,
                          (2 + i > 255) ? 255 : 2 + i, 9, "satStall");
        applyIdle(ADV,0,255,9, "satHold");

        // Asynchronous reset in the middle of FLUSH
        applyStimulus(1,1,0,0,0,0,0,0,0,0, BRANCH,0,255,9, "preReset");
        applyStimulus(0,0,0,0,0,0,0,0,0,0, INITP,0,0,0, "asyncReset");
        applyStimulus(0,0,0,0,0,0,0,0,0,0, INITP,0,0,0, "resetHold");
        applyIdle(INITP,0,0,0, "reInit");
        applyIdle(ADV,0,0,0, "reRun");

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clock);
        @(posedge clock);
        if (expQ.size() > 0) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL drain: %0d expected entries left, want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
